// File: rtl/branch_redirect_controller_pkg.sv
// Shared CPU definitions for the branch redirect controller: FSM state
// encoding and the default instruction address width.
package branch_redirect_controller_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    HOLD     = 2'd1,
    REDIRECT = 2'd2,
    FLUSH    = 2'd3
  } state_t;

  localparam int ADDR_W_DEFAULT = 9;

  // Width of the remaining-flush-cycles counter; FLUSH_CYCLES tops out at 15.
  localparam int FLUSH_REM_W = 4;

endpackage

// File: rtl/branch_redirect_controller_sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones.
module sat_counter
  import branch_redirect_controller_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Clear wins over increment; increment stops once all bits are set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/branch_redirect_controller.sv
// Sequences the PC redirect and IF/ID, ID/EX flushes after a taken branch
// resolved in EX, honouring hazard-unit stalls, and keeps saturating
// counts of accepted branches and effective flush cycles.
module branch_redirect_controller
  import branch_redirect_controller_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEFAULT,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ex_valid,
  input  logic              ex_branch,
  input  logic [ADDR_W-1:0] ex_target,
  input  logic              stall,
  input  logic              cnt_clr,
  output logic              pc_load,
  output logic [ADDR_W-1:0] pc_target,
  output logic              flush_if_id,
  output logic              flush_id_ex,
  output logic              busy,
  output logic [CNT_W-1:0]  taken_count,
  output logic [CNT_W-1:0]  flush_count
);

  state_t                   state;
  state_t                   state_next;
  logic [FLUSH_REM_W-1:0]   rem;
  logic [FLUSH_REM_W-1:0]   rem_next;
  logic [ADDR_W-1:0]        target_q;
  logic [ADDR_W-1:0]        target_next;
  logic                     accept;
  logic                     taken_inc;
  logic                     flush_inc;

  assign accept    = ex_valid & ex_branch;
  assign pc_target = target_q;
  assign flush_inc = flush_if_id & ~stall;

  // Next-state logic plus Moore output decode; branches are only looked at
  // in IDLE because anything in EX while redirecting is a wrong-path op.
  always_comb begin
    state_next  = state;
    rem_next    = rem;
    target_next = target_q;
    taken_inc   = 1'b0;
    pc_load     = 1'b0;
    flush_if_id = 1'b0;
    flush_id_ex = 1'b0;
    busy        = (state != IDLE);
    case (state)
      IDLE: begin
        if (accept) begin
          target_next = ex_target;
          taken_inc   = 1'b1;
          state_next  = stall ? HOLD : REDIRECT;
        end
      end
      HOLD: begin
        if (!stall) begin
          state_next = REDIRECT;
        end
      end
      REDIRECT: begin
        pc_load     = 1'b1;
        flush_if_id = 1'b1;
        flush_id_ex = 1'b1;
        if (!stall) begin
          if (FLUSH_CYCLES == 1) begin
            state_next = IDLE;
          end else begin
            state_next = FLUSH;
            rem_next   = FLUSH_REM_W'(FLUSH_CYCLES - 2);
          end
        end
      end
      FLUSH: begin
        flush_if_id = 1'b1;
        flush_id_ex = 1'b1;
        if (!stall) begin
          if (rem == '0) begin
            state_next = IDLE;
          end else begin
            rem_next = rem - FLUSH_REM_W'(1);
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State, remaining-flush counter and redirect target registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      rem      <= '0;
      target_q <= '0;
    end else begin
      state    <= state_next;
      rem      <= rem_next;
      target_q <= target_next;
    end
  end

  sat_counter #(.W(CNT_W)) u_taken_counter (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .inc   (taken_inc),
    .count (taken_count)
  );

  sat_counter #(.W(CNT_W)) u_flush_counter (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .inc   (flush_inc),
    .count (flush_count)
  );

endmodule
